// File: rtl/wash_sequencer.sv
// Washing machine run controller: selection, run/pause/done FSM, 1 s time base,
// wash/rinse/spin phase countdown and valve/buzzer drive.
module wash_sequencer #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned BUZZ_SEC = 5
) (
  input  logic       clk,
  input  logic       power_light,
  input  logic       start_pause,
  input  logic       model_next,
  input  logic       water_next,
  output logic [1:0] run_state,
  output logic [2:0] current_model,
  output logic [2:0] current_water,
  output logic [1:0] current_program,
  output logic [6:0] phase_time,
  output logic [6:0] total_time,
  output logic       in_water,
  output logic       out_water,
  output logic       buzzer
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned CntW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BuzzW = (BUZZ_SEC > 0) ? $clog2(BUZZ_SEC + 1) : 1;
  localparam logic [CntW-1:0]  TickMax  = CntW'(TICK_DIV - 1);
  localparam logic [BuzzW-1:0] BuzzLoad = BuzzW'(BUZZ_SEC);

  state_e           state_q, state_d;
  logic [2:0]       model_q, model_d, water_q, water_d;
  logic [1:0]       prog_q, prog_d;
  logic [6:0]       phase_q, phase_d, total_q, total_d;
  logic [CntW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BuzzW-1:0] buzz_q, buzz_d;
  logic             buzzer_q, buzzer_d;

  logic       tick;
  logic [2:0] mask;
  logic [1:0] first_prog, next_prog;
  logic       has_next;
  logic [6:0] plan_total, w7, elapsed;

  function automatic logic [6:0] dur(input logic [1:0] prog, input logic [2:0] w);
    logic [6:0] wx;
    wx = {4'd0, w};
    case (prog)
      2'd0:    dur = 7'd9 + wx;
      2'd1:    dur = 7'd9 + (wx << 1);
      default: dur = 7'd3 + wx;
    endcase
  endfunction

  // Bit 0 wash, bit 1 rinse, bit 2 spin.
  function automatic logic [2:0] phase_mask(input logic [2:0] m);
    case (m)
      3'd0:    phase_mask = 3'b111;
      3'd1:    phase_mask = 3'b001;
      3'd2:    phase_mask = 3'b011;
      3'd3:    phase_mask = 3'b010;
      3'd4:    phase_mask = 3'b110;
      default: phase_mask = 3'b100;
    endcase
  endfunction

  assign w7   = {4'd0, water_q};
  assign mask = phase_mask(model_q);
  assign tick = ((state_q == StRun) || (state_q == StDone)) && (tick_cnt_q == TickMax);

  always_comb begin
    first_prog = mask[0] ? 2'd0 : (mask[1] ? 2'd1 : 2'd2);
    plan_total = (mask[0] ? dur(2'd0, water_q) : 7'd0) +
                 (mask[1] ? dur(2'd1, water_q) : 7'd0) +
                 (mask[2] ? dur(2'd2, water_q) : 7'd0);
    has_next   = 1'b0;
    next_prog  = 2'd2;
    if (prog_q == 2'd0 && mask[1]) begin
      has_next  = 1'b1;
      next_prog = 2'd1;
    end else if (prog_q != 2'd2 && mask[2]) begin
      has_next  = 1'b1;
      next_prog = 2'd2;
    end
  end

  always_comb begin
    state_d    = state_q;
    model_d    = model_q;
    water_d    = water_q;
    prog_d     = prog_q;
    phase_d    = phase_q;
    total_d    = total_q;
    tick_cnt_d = tick_cnt_q;
    buzz_d     = buzz_q;
    buzzer_d   = buzzer_q;

    if (state_q == StRun || state_q == StDone) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (model_next) model_d = (model_q >= 3'd5) ? 3'd0 : model_q + 3'd1;
        if (water_next) water_d = (water_q >= 3'd5) ? 3'd1 : water_q + 3'd1;
        prog_d  = first_prog;
        phase_d = dur(first_prog, water_q);
        total_d = plan_total;
        if (start_pause) begin
          state_d    = StRun;
          tick_cnt_d = '0;
        end
      end
      StRun: begin
        if (start_pause) state_d = StPause;
        if (tick) begin
          total_d = total_q - 7'd1;
          if (phase_q > 7'd1) begin
            phase_d = phase_q - 7'd1;
          end else if (has_next) begin
            prog_d  = next_prog;
            phase_d = dur(next_prog, water_q);
          end else begin
            // Finishing the programme takes priority over a coincident pause.
            state_d  = StDone;
            phase_d  = 7'd0;
            total_d  = 7'd0;
            buzzer_d = 1'b1;
            buzz_d   = BuzzLoad;
          end
        end
      end
      StPause: begin
        if (start_pause) state_d = StRun;
      end
      StDone: begin
        if (start_pause) begin
          state_d  = StIdle;
          buzzer_d = 1'b0;
        end else if (tick) begin
          buzz_d = buzz_q - 1'b1;
          if (buzz_q <= 1) begin
            state_d  = StIdle;
            buzzer_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge power_light) begin
    if (!power_light) begin
      state_q    <= StIdle;
      model_q    <= 3'd0;
      water_q    <= 3'd3;
      prog_q     <= 2'd0;
      phase_q    <= 7'd12;
      total_q    <= 7'd33;
      tick_cnt_q <= '0;
      buzz_q     <= '0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      model_q    <= model_d;
      water_q    <= water_d;
      prog_q     <= prog_d;
      phase_q    <= phase_d;
      total_q    <= total_d;
      tick_cnt_q <= tick_cnt_d;
      buzz_q     <= buzz_d;
      buzzer_q   <= buzzer_d;
    end
  end

  // Seconds already spent in the current phase drive the valve schedule.
  assign elapsed = dur(prog_q, water_q) - phase_q;

  always_comb begin
    in_water  = 1'b0;
    out_water = 1'b0;
    if (state_q == StRun) begin
      case (prog_q)
        2'd0: in_water = (elapsed < w7);
        2'd1: begin
          out_water = (elapsed < w7 + 7'd3);
          in_water  = (elapsed >= w7 + 7'd3) && (elapsed < (w7 << 1) + 7'd3);
        end
        default: out_water = 1'b1;
      endcase
    end
  end

  assign run_state       = state_q;
  assign current_model   = model_q;
  assign current_water   = water_q;
  assign current_program = prog_q;
  assign phase_time      = phase_q;
  assign total_time      = total_q;
  assign buzzer          = buzzer_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer with TICK_DIV=4, BUZZ_SEC=5.
module tb_wash_sequencer;

  logic       clk = 1'b0;
  logic       power_light = 1'b1;
  logic       start_pause = 1'b0;
  logic       model_next = 1'b0;
  logic       water_next = 1'b0;
  logic [1:0] run_state;
  logic [2:0] current_model;
  logic [2:0] current_water;
  logic [1:0] current_program;
  logic [6:0] phase_time;
  logic [6:0] total_time;
  logic       in_water;
  logic       out_water;
  logic       buzzer;

  wash_sequencer #(
    .TICK_DIV(4),
    .BUZZ_SEC(5)
  ) dut (
    .clk            (clk),
    .power_light    (power_light),
    .start_pause    (start_pause),
    .model_next     (model_next),
    .water_next     (water_next),
    .run_state      (run_state),
    .current_model  (current_model),
    .current_water  (current_water),
    .current_program(current_program),
    .phase_time     (phase_time),
    .total_time     (total_time),
    .in_water       (in_water),
    .out_water      (out_water),
    .buzzer         (buzzer)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    int w;
    int prog;
    int phase;
    int total;
  } vec_t;

  vec_t vecs[8];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cur_m = 0;
  int   cur_w = 3;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start_pause = 1'b1;
    cyc(1);
    start_pause = 1'b0;
  endtask

  task automatic pulse_model();
    model_next = 1'b1;
    cyc(1);
    model_next = 1'b0;
  endtask

  task automatic pulse_water();
    water_next = 1'b1;
    cyc(1);
    water_next = 1'b0;
  endtask

  task automatic select(input int m, input int w);
    int nm;
    int nw;
    nm = (m - cur_m + 6) % 6;
    nw = (w - cur_w + 5) % 5;
    for (int i = 0; i < nm; i++) pulse_model();
    for (int i = 0; i < nw; i++) pulse_water();
    cur_m = m;
    cur_w = w;
    cyc(1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_run"}, run_state, 0);
    chk({tag, "_model"}, current_model, 0);
    chk({tag, "_water"}, current_water, 3);
    chk({tag, "_prog"}, current_program, 0);
    chk({tag, "_phase"}, phase_time, 12);
    chk({tag, "_total"}, total_time, 33);
    chk({tag, "_in"}, in_water, 0);
    chk({tag, "_out"}, out_water, 0);
    chk({tag, "_buzz"}, buzzer, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int sec;
    vecs[0] = '{0, 1, 0, 10, 25};
    vecs[1] = '{1, 2, 0, 11, 11};
    vecs[2] = '{2, 3, 0, 12, 27};
    vecs[3] = '{3, 4, 1, 17, 17};
    vecs[4] = '{4, 5, 1, 19, 27};
    vecs[5] = '{5, 5, 2, 8, 8};
    vecs[6] = '{0, 5, 0, 14, 41};
    vecs[7] = '{5, 1, 2, 4, 4};

    // Power-on reset
    #1 power_light = 1'b0;
    cyc(2);
    chk_reset_vals("reset");
    power_light = 1'b1;
    cyc(1);

    // Selection wrap and plan latency
    for (int i = 0; i < 6; i++) pulse_model();
    chk("model_wrap", current_model, 0);
    for (int i = 0; i < 3; i++) pulse_water();
    chk("water_wrap", current_water, 1);
    chk("plan_latency_old", total_time, 41);
    cyc(1);
    chk("plan_latency_new", total_time, 25);
    cur_m = 0;
    cur_w = 1;

    // Plan table through the scoreboard
    for (int i = 0; i < 8; i++) begin
      select(vecs[i].m, vecs[i].w);
      sb_q.push_back(vecs[i]);
      v = sb_q.pop_front();
      chk($sformatf("tbl%0d_prog", i), current_program, v.prog);
      chk($sformatf("tbl%0d_phase", i), phase_time, v.phase);
      chk($sformatf("tbl%0d_total", i), total_time, v.total);
      chk($sformatf("tbl%0d_run", i), run_state, 0);
    end

    // Model 1, water 1: wash-only run, DONE, buzzer timeout
    select(1, 1);
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      chk("m1_phase", phase_time, 10 - i / 4);
      chk("m1_total", total_time, 10 - i / 4);
      chk("m1_in", in_water, (i < 4) ? 1 : 0);
      chk("m1_out", out_water, 0);
      cyc(1);
    end
    chk("m1_done_run", run_state, 3);
    chk("m1_done_buzz", buzzer, 1);
    chk("m1_done_phase", phase_time, 0);
    chk("m1_done_total", total_time, 0);
    cyc(19);
    chk("m1_buzz_hold_run", run_state, 3);
    chk("m1_buzz_hold", buzzer, 1);
    cyc(1);
    chk("m1_idle_run", run_state, 0);
    chk("m1_idle_buzz", buzzer, 0);
    cyc(1);
    chk("m1_reload_phase", phase_time, 10);
    chk("m1_reload_total", total_time, 10);

    // Model 4, water 2: rinse then spin
    select(4, 2);
    pulse_start();
    for (int i = 0; i < 72; i++) begin
      sec = i / 4;
      if (sec < 13) begin
        chk("m4_prog", current_program, 1);
        chk("m4_phase", phase_time, 13 - sec);
        chk("m4_out", out_water, (sec < 5) ? 1 : 0);
        chk("m4_in", in_water, (sec >= 5 && sec < 7) ? 1 : 0);
      end else begin
        chk("m4_prog", current_program, 2);
        chk("m4_phase", phase_time, 18 - sec);
        chk("m4_out", out_water, 1);
        chk("m4_in", in_water, 0);
      end
      chk("m4_total", total_time, 18 - sec);
      cyc(1);
    end
    chk("m4_done_run", run_state, 3);
    chk("m4_done_total", total_time, 0);
    chk("m4_done_buzz", buzzer, 1);
    pulse_start();
    chk("done_start_run", run_state, 0);
    chk("done_start_buzz", buzzer, 0);

    // Model 0, water 5: pause freezes timers and the partial second
    select(0, 5);
    pulse_start();
    chk("p_start_phase", phase_time, 14);
    chk("p_start_total", total_time, 41);
    cyc(5);
    chk("p_pre_phase", phase_time, 13);
    chk("p_pre_in", in_water, 1);
    pulse_start();
    chk("p_run", run_state, 2);
    chk("p_in", in_water, 0);
    chk("p_out", out_water, 0);
    pulse_model();
    pulse_water();
    chk("p_model_ignored", current_model, 0);
    chk("p_water_ignored", current_water, 5);
    for (int i = 0; i < 98; i++) begin
      cyc(1);
      chk("p_frozen_phase", phase_time, 13);
    end
    chk("p_frozen_total", total_time, 40);
    chk("p_frozen_in", in_water, 0);
    pulse_start();
    chk("r_run", run_state, 1);
    chk("r_in", in_water, 1);
    chk("r_phase0", phase_time, 13);
    cyc(1);
    chk("r_phase1", phase_time, 13);
    cyc(1);
    chk("r_phase2", phase_time, 12);
    chk("r_total2", total_time, 39);

    // Pause on the same cycle as the phase-ending tick
    cyc(47);
    chk("pt_phase_before", phase_time, 1);
    chk("pt_total_before", total_time, 28);
    pulse_start();
    chk("pt_run", run_state, 2);
    chk("pt_prog", current_program, 1);
    chk("pt_phase", phase_time, 19);
    chk("pt_total", total_time, 27);
    chk("pt_out", out_water, 0);

    // Power loss mid-rinse
    pulse_start();
    chk("pl_run", run_state, 1);
    chk("pl_out", out_water, 1);
    cyc(1);
    power_light = 1'b0;
    #1;
    chk_reset_vals("pwr");
    cyc(1);
    power_light = 1'b1;
    cur_m = 0;
    cur_w = 3;
    cyc(2);
    chk("pwr_rel_run", run_state, 0);
    chk("pwr_rel_phase", phase_time, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
